// File: rtl/cfg_pkg.sv
// ============================================================================
// Module  : cfg_pkg
// Brief   : Shared types and helpers for the routing-tile configuration loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    // Zero prog: X nodes pass straight through, Y outputs forced low.
    localparam logic SAFE_PROG_BIT = 1'b0;

    function automatic int cfg_nwords(input int prog_w, input int w);
        return (prog_w + w - 1) / w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_shadow_reg.sv
// ============================================================================
// Module  : cfg_shadow_reg
// Brief   : Word-indexed shadow register; bits past PROG_W in the last word drop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfg_shadow_reg
    import cfg_pkg::*;
#(
    parameter int PROG_W = 20,
    parameter int W      = 8,
    parameter int NWORDS = cfg_nwords(PROG_W, W),
    parameter int CNT_W  = $clog2(NWORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [W-1:0]      wr_data,
    output logic [PROG_W-1:0] shadow
);

    logic [PROG_W-1:0] shadow_q;
    logic [PROG_W-1:0] shadow_d;

    generate
        for (genvar i = 0; i < PROG_W; i++) begin : g_bit
            localparam int WORD_IDX = i / W;
            localparam int BIT_IDX  = i % W;
            assign shadow_d[i] = (wr_en && (wr_idx == CNT_W'(WORD_IDX)))
                               ? wr_data[BIT_IDX] : shadow_q[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= {PROG_W{SAFE_PROG_BIT}};
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

`default_nettype wire

// File: rtl/route_cfg_loader.sv
// ============================================================================
// Module  : route_cfg_loader
// Brief   : Loads a checksummed config frame and commits it atomically to prog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module route_cfg_loader
    import cfg_pkg::*;
#(
    parameter int V = 4,
    parameter int H = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_abort,
    input  logic [W-1:0]   cfg_data,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic [V*H-1:0] x_prog,
    output logic [V-1:0]   y_prog,
    output logic           cfg_busy,
    output logic           cfg_done,
    output logic           cfg_err
);

    localparam int PROG_W = V * H + V;
    localparam int NWORDS = cfg_nwords(PROG_W, W);
    localparam int CNT_W  = $clog2(NWORDS + 1);

    cfg_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      cksum_q, cksum_d;
    logic [V*H-1:0]    x_prog_q, x_prog_d;
    logic [V-1:0]      y_prog_q, y_prog_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic [PROG_W-1:0] shadow;

    cfg_shadow_reg #(
        .PROG_W (PROG_W),
        .W      (W),
        .NWORDS (NWORDS),
        .CNT_W  (CNT_W)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (cnt_q),
        .wr_data (cfg_data),
        .shadow  (shadow)
    );

    // Ready depends on state alone so there is no comb path from cfg_valid.
    assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cksum_d  = cksum_q;
        x_prog_d = x_prog_q;
        y_prog_d = y_prog_q;
        done_d   = 1'b0;
        err_d    = err_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    cksum_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (cfg_valid) begin
                    wr_en   = 1'b1;
                    cksum_d = cksum_q ^ cfg_data;
                    if (cnt_q == CNT_W'(NWORDS - 1)) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (cfg_valid) begin
                    if (cfg_data == cksum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                x_prog_d = shadow[V*H-1:0];
                y_prog_d = shadow[PROG_W-1:V*H];
                done_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cksum_q  <= '0;
            x_prog_q <= {(V*H){SAFE_PROG_BIT}};
            y_prog_q <= {V{SAFE_PROG_BIT}};
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cksum_q  <= cksum_d;
            x_prog_q <= x_prog_d;
            y_prog_q <= y_prog_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign x_prog   = x_prog_q;
    assign y_prog   = y_prog_q;
    assign cfg_busy = (state_q != IDLE);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

endmodule

`default_nettype wire
